// File: rtl/result_streamer.sv
// result_streamer: snapshots the four systolic-array accumulations on a
// capture pulse, then streams them to the host one byte per handshake,
// either saturated to int8 or as full 16-bit values (low byte first).
module result_streamer #(
    parameter int ACC_W   = 16,
    parameter int OUT_W   = 8,
    parameter int NUM_RES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    capture,
    input  logic                    activation,
    input  logic                    full_mode,
    input  logic signed [ACC_W-1:0] c00,
    input  logic signed [ACC_W-1:0] c01,
    input  logic signed [ACC_W-1:0] c10,
    input  logic signed [ACC_W-1:0] c11,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_data,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int IDX_W = $clog2(2 * NUM_RES);
    localparam int RES_W = $clog2(NUM_RES);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic signed [ACC_W-1:0] snap [NUM_RES];
    logic                    act_q;
    logic                    full_q;
    logic [IDX_W-1:0]        idx;
    logic                    fire;
    logic                    last;
    logic [RES_W-1:0]        res_sel;
    logic signed [ACC_W-1:0] cur_raw;
    logic signed [ACC_W-1:0] cur_val;
    logic [OUT_W-1:0]        sat_byte;
    logic [OUT_W-1:0]        byte_sel;

    assign fire = (state == STREAM) && out_ready;
    assign last = (idx == (full_q ? IDX_W'(2 * NUM_RES - 1) : IDX_W'(NUM_RES - 1)));

    // State register; everything returns to IDLE on reset, abandoning any stream
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: start on capture, finish once the final byte has been accepted
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = STREAM;
            STREAM:  if (fire && last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Snapshot, mode latches, byte index, done pulse and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_RES; i++) snap[i] <= '0;
            act_q    <= 1'b0;
            full_q   <= 1'b0;
            idx      <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= fire && last;
            if (state == IDLE && capture) begin
                snap[0]  <= c00;
                snap[1]  <= c01;
                snap[2]  <= c10;
                snap[3]  <= c11;
                act_q    <= activation;
                full_q   <= full_mode;
                idx      <= '0;
                overflow <= 1'b0;
            end else begin
                if (state == STREAM && capture) overflow <= 1'b1;
                if (fire && !last) idx <= idx + IDX_W'(1);
            end
        end
    end

    // Byte formatting: pick the result, apply the latched ReLU, then saturate or split
    always_comb begin
        res_sel  = full_q ? idx[IDX_W-1:1] : idx[RES_W-1:0];
        cur_raw  = snap[res_sel];
        cur_val  = (act_q && cur_raw[ACC_W-1]) ? '0 : cur_raw;
        sat_byte = cur_val[OUT_W-1:0];
        if (cur_val > SAT_MAX) begin
            sat_byte = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (cur_val < SAT_MIN) begin
            sat_byte = {1'b1, {(OUT_W - 1){1'b0}}};
        end
        byte_sel = sat_byte;
        if (full_q) begin
            byte_sel = idx[0] ? cur_val[ACC_W-1:OUT_W] : cur_val[OUT_W-1:0];
        end
    end

    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_data  = (state == STREAM) ? byte_sel : '0;

endmodule

// File: tb/tb_result_streamer.sv
// tb_result_streamer: table-driven vectors for the streaming formats plus
// hand-written sequences for backpressure, overflow and mid-stream reset.
module tb_result_streamer;

    logic               clk = 1'b0;
    logic               rst;
    logic               capture;
    logic               activation;
    logic               full_mode;
    logic signed [15:0] c00, c01, c10, c11;
    logic               out_ready;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               busy;
    logic               done;
    logic               overflow;

    int n_vectors    = 0;
    int n_miscompare = 0;

    // Packed arrays are listed last element first, so c[0] / exp[0] is the rightmost entry
    typedef struct {
        logic             act;
        logic             full;
        logic [3:0][15:0] c;
        int               nbytes;
        logic [7:0][7:0]  exp;
    } vec_t;

    vec_t vecs [5];

    result_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .activation (activation),
        .full_mode  (full_mode),
        .c00        (c00),
        .c01        (c01),
        .c10        (c10),
        .c11        (c11),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompare++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; the capture pulse spans exactly one rising edge
    task automatic applyStimulus(input logic act, input logic full, input logic [3:0][15:0] c);
        activation = act;
        full_mode  = full;
        c00        = c[0];
        c01        = c[1];
        c10        = c[2];
        c11        = c[3];
        capture    = 1'b1;
        @(negedge clk);
        capture    = 1'b0;
    endtask

    // With out_ready high, expects one byte per cycle, then a single done pulse
    task automatic expect_stream(input string tag, input logic [7:0][7:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s valid[%0d]", tag, i), 16'(out_valid), 16'h1);
            checkOutput($sformatf("%s byte[%0d]", tag, i), 16'(out_data), 16'(exp[i]));
            @(negedge clk);
        end
        checkOutput({tag, " done"}, 16'(done), 16'h1);
        checkOutput({tag, " valid_after"}, 16'(out_valid), 16'h0);
        checkOutput({tag, " busy_after"}, 16'(busy), 16'h0);
        @(negedge clk);
        checkOutput({tag, " done_once"}, 16'(done), 16'h0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, {16'hFFFB, 16'h0005, 16'hFF00, 16'h0190}, 4,
                    {32'h0, 8'hFB, 8'h05, 8'h80, 8'h7F}};
        vecs[1] = '{1'b1, 1'b0, {16'hFFFB, 16'h0005, 16'hFF00, 16'h0190}, 4,
                    {32'h0, 8'h00, 8'h05, 8'h00, 8'h7F}};
        vecs[2] = '{1'b0, 1'b1, {16'hFFFF, 16'h0000, 16'h8001, 16'h1234}, 8,
                    {8'hFF, 8'hFF, 8'h00, 8'h00, 8'h80, 8'h01, 8'h12, 8'h34}};
        vecs[3] = '{1'b1, 1'b1, {16'hFFFF, 16'h0000, 16'h8001, 16'h1234}, 8,
                    {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34}};
        vecs[4] = '{1'b0, 1'b0, {16'hFF7F, 16'hFF80, 16'h0080, 16'h007F}, 4,
                    {32'h0, 8'h80, 8'h80, 8'h7F, 8'h7F}};

        rst        = 1'b1;
        capture    = 1'b0;
        activation = 1'b0;
        full_mode  = 1'b0;
        c00        = 16'h1111;
        c01        = 16'h2222;
        c10        = 16'h3333;
        c11        = 16'h4444;
        out_ready  = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset out_data", 16'(out_data), 16'h0);
        checkOutput("reset out_valid", 16'(out_valid), 16'h0);
        checkOutput("reset busy", 16'(busy), 16'h0);
        checkOutput("reset done", 16'(done), 16'h0);
        checkOutput("reset overflow", 16'(overflow), 16'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle valid", 16'(out_valid), 16'h0);

        // Vector table; mode inputs flip mid-stream to prove the latched copies are used
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].act, vecs[v].full, vecs[v].c);
            activation = ~vecs[v].act;
            full_mode  = ~vecs[v].full;
            expect_stream($sformatf("vec%0d", v), vecs[v].exp, vecs[v].nbytes);
        end

        // Backpressure: first byte must hold steady while the host stalls
        out_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, vecs[0].c);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("stall valid[%0d]", i), 16'(out_valid), 16'h1);
            checkOutput($sformatf("stall byte[%0d]", i), 16'(out_data), 16'h7F);
            checkOutput($sformatf("stall done[%0d]", i), 16'(done), 16'h0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        expect_stream("stall", vecs[0].exp, 4);

        // Capture while streaming is ignored and raises the sticky overflow flag
        applyStimulus(1'b0, 1'b0, vecs[0].c);
        checkOutput("ovf byte0", 16'(out_data), 16'h7F);
        c00 = 16'h0001; c01 = 16'h0002; c10 = 16'h0003; c11 = 16'h0004;
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        checkOutput("ovf flag", 16'(overflow), 16'h1);
        checkOutput("ovf byte1", 16'(out_data), 16'h80);
        @(negedge clk);
        checkOutput("ovf byte2", 16'(out_data), 16'h05);
        @(negedge clk);
        checkOutput("ovf byte3", 16'(out_data), 16'hFB);
        @(negedge clk);
        checkOutput("ovf done", 16'(done), 16'h1);
        checkOutput("ovf held", 16'(overflow), 16'h1);
        @(negedge clk);

        // An accepted capture clears overflow; a capture on the last transfer sets it again
        applyStimulus(1'b0, 1'b1, vecs[2].c);
        checkOutput("ovf cleared", 16'(overflow), 16'h0);
        for (int i = 0; i < 7; i++) begin
            checkOutput($sformatf("lastcap byte[%0d]", i), 16'(out_data), 16'(vecs[2].exp[i]));
            @(negedge clk);
        end
        checkOutput("lastcap byte[7]", 16'(out_data), 16'(vecs[2].exp[7]));
        capture = 1'b1;
        @(negedge clk);
        capture = 1'b0;
        checkOutput("lastcap done", 16'(done), 16'h1);
        checkOutput("lastcap busy", 16'(busy), 16'h0);
        checkOutput("lastcap overflow", 16'(overflow), 16'h1);
        @(negedge clk);
        checkOutput("lastcap ignored", 16'(busy), 16'h0);

        // Reset after two bytes abandons the stream without a done pulse
        applyStimulus(1'b0, 1'b0, vecs[0].c);
        checkOutput("rst byte0", 16'(out_data), 16'h7F);
        @(negedge clk);
        checkOutput("rst byte1", 16'(out_data), 16'h80);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("rst valid", 16'(out_valid), 16'h0);
        checkOutput("rst busy", 16'(busy), 16'h0);
        checkOutput("rst data", 16'(out_data), 16'h0);
        checkOutput("rst overflow", 16'(overflow), 16'h0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rst no_done[%0d]", i), 16'(done), 16'h0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, vecs[0].c);
        expect_stream("restart", vecs[0].exp, 4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompare);
        $finish;
    end

endmodule
